stream_count_unit: RTL and testbench
====================================

# stream_count_unit

Parametrised successor to the start-triggered read/convert/count/write pipeline. A single FSM loads a word count and mode, then accepts that many input words through a valid/ready handshake. Each word folds into a signed running counter according to the selected mode (word count, popcount, signed sum or negative count), with optional saturation. It then presents the final count on a valid/ready result port. It sits between the input-word source and the result writer, replacing the fixed-width `ldn`/`readData`/`enC`/`writeToFile` sequencing.

## Interface
- `WIDTH`, 8: input word width in bits; words are treated as two's-complement signed.
- `CNT_W`, 32: counter/result width, signed; must be at least `WIDTH`+1.
- `LEN_W`, 8: width of the word-count field.
- `SAT`, 0: 1 = saturate the counter at signed min/max; 0 = wrap modulo 2^CNT_W.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  LEN_W  number of words in the run; latched on start.
- `mode`  in  2  0 = count words, 1 = popcount, 2 = signed sum, 3 = count negative words; latched on start.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_data`  out  CNT_W  final signed count.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `cnt`  out  CNT_W  running signed count (debug/observe).
- `busy`  out  1  high in any state except IDLE.
- `ovf`  out  1  sticky overflow flag for the current run.

## Operation
- **States:** IDLE, LOAD, READ, WRITE.
- **IDLE:**
  - With `start`=1, go to LOAD.
  - Latch `len` into `remaining` and `mode` into `mode_q`.
- **LOAD:** one cycle.
  - Clear `cnt` and `ovf`.
  - Go to READ if `remaining`!=0, otherwise to WRITE.
- **READ:**
  - `in_ready`=1.
  - On handshake (`in_valid` & `in_ready`), add the contribution to `cnt` and decrement `remaining`.
  - When the handshake consumes the last word (`remaining`==1), go to WRITE.
  - When `in_valid`=0, hold all state.
- **WRITE:**
  - `out_valid`=1 and `out_data`=`cnt`, held stable until `out_ready`=1.
  - On handshake, go to IDLE.
  - `out_valid` drops the next cycle.
- **Contribution per mode:**
  - mode 0: +1.
  - mode 1: number of set bits in `in_data` (zero-extended).
  - mode 2: `in_data` sign-extended to CNT_W.
  - mode 3: +1 if `in_data[WIDTH-1]`=1, else +0.
- **Arithmetic:** the sum is computed at CNT_W+1 bits.
  - On signed overflow, set `ovf`.
  - With `SAT`=1, clamp to 2^(CNT_W-1)-1 or -2^(CNT_W-1).
  - With `SAT`=0, keep the low CNT_W bits.
- **`start` outside IDLE:** ignored; `len` and `mode` changes mid-run have no effect.
- **Run boundaries:** `cnt` and `ovf` keep their final values after WRITE until the next LOAD.

## Timing
- **Reset:** `rst`=0 at a rising edge forces IDLE in any state, including mid-READ or mid-WRITE. After that edge:
  - `cnt`=0, `out_data`=0, `ovf`=0.
  - `out_valid`=0, `in_ready`=0, `busy`=0, `remaining`=0.
- **Reset priority:** reset beats `start` in the same cycle.
- **Output registration:**
  - `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
  - `cnt`, `out_data` and `ovf` are registered.
- **Update latency:** `cnt` reflects a word in the cycle after its handshake.
- **Cycle numbering:** `start` sampled at edge 0.
  - LOAD during cycle 1.
  - `in_ready`=1 from cycle 2.
- **Latency with continuous `in_valid`:**
  - Words are consumed at edges 2..N+1.
  - `out_valid`=1 from cycle N+2 with the final count.
- **len=0:** LOAD→WRITE; `out_valid`=1 in cycle 2 with `out_data`=0.
- **Back-to-back runs:** a `start` in the first IDLE cycle after the WRITE handshake is accepted. There is no dead cycle beyond IDLE itself.
- **Last-word overflow:** overflow on the final word still sets `ovf` before `out_valid` rises.

## Test plan
All scenarios use WIDTH=8, CNT_W=32, LEN_W=8, SAT=0 unless stated otherwise.
- **Word count:** mode 0, len=5, `in_valid` held at 1, `out_ready`=1 -> `out_valid` in cycle 7 after `start`, `out_data`=5, `ovf`=0, `busy` 1 for cycles 1..7.
- **Signed sum:** mode 2, words -3, 10, -128, 127 -> `out_data`=6; `cnt` trace 0, -3, 7, -121, 6.
- **Popcount with gaps:** mode 1, words 0xFF, 0x0F, 0x00 with `in_valid` low 2 cycles between words -> `out_data`=12; `remaining` and `cnt` unchanged during gaps.
- **Empty run and backpressure:** len=0 with `out_ready`=0 for 3 cycles and `start` pulsed in WRITE -> `out_valid` stays 1, `out_data`=0 stable, the extra `start` is ignored, IDLE the cycle after `out_ready`=1.
- **Overflow:** CNT_W=8, mode 2, words 100, 100.
  - With SAT=1 -> `out_data`=127, `ovf`=1.
  - With SAT=0 -> `out_data`=-56, `ovf`=1.
  - Following run with len=1, word 1 -> `ovf`=0, `out_data`=1.
- **Reset mid-run:** `rst`=0 for one edge after 2 of 4 words in mode 3 -> next cycle IDLE, `cnt`=0, `in_ready`=0, `busy`=0. A new run of -1, -2, 3 then yields `out_data`=2.

Source files
------------

// File: rtl/stream_count_unit.sv
// Start-triggered stream counter: latches a word count and mode, folds each accepted
// word into a signed running count (optionally saturating), then hands the result out.
module stream_count_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32,
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, WRITE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [CNT_W:0]     contrib;
  logic [CNT_W:0]     sumWide;
  logic               sumOvf;
  logic [CNT_W-1:0]   sumNext;

  // One extra bit of headroom lets the top two bits reveal signed overflow.
  always_comb begin
    contrib = '0;
    case (mode_q)
      2'd0: contrib = (CNT_W+1)'(1);
      2'd1: begin
        for (int i = 0; i < WIDTH; i++) begin
          contrib = contrib + (CNT_W+1)'(in_data[i]);
        end
      end
      2'd2: contrib = {{(CNT_W+1-WIDTH){in_data[WIDTH-1]}}, in_data};
      default: contrib = (CNT_W+1)'(in_data[WIDTH-1]);
    endcase

    sumWide = {cnt_q[CNT_W-1], cnt_q} + contrib;
    sumOvf  = sumWide[CNT_W] ^ sumWide[CNT_W-1];
    if (SAT && sumOvf) begin
      sumNext = sumWide[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
    end else begin
      sumNext = sumWide[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          remaining_d = len;
          mode_d      = mode;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = (remaining_q != '0) ? READ : WRITE;
      end
      READ: begin
        if (in_valid) begin
          cnt_d       = sumNext;
          ovf_d       = ovf_q | sumOvf;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // cnt holds its final value through WRITE, so the result port can mirror it directly.
  assign in_ready  = (state_q == READ);
  assign out_valid = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign cnt       = cnt_q;
  assign out_data  = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_stream_count_unit.sv
// Directed bench for stream_count_unit: a default 32-bit instance plus two 8-bit
// counter instances (saturating and wrapping) sharing the same stimulus.
module tb_stream_count_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic [1:0] mode;
  logic [7:0] inData;
  logic       inValid;
  logic       outReady;

  logic        inReady, outValid, busy, ovf;
  logic [31:0] outData, cnt;

  logic       satInReady, satOutValid, satBusy, satOvf;
  logic [7:0] satOutData, satCnt;

  logic       wrapInReady, wrapOutValid, wrapBusy, wrapOvf;
  logic [7:0] wrapOutData, wrapCnt;

  int compareCount = 0;
  int failCount    = 0;

  logic [7:0] sumWords [4] = '{8'hFD, 8'h0A, 8'h80, 8'h7F};
  int         sumTrace [4] = '{-3, 7, -121, 6};
  logic [7:0] popWords [3] = '{8'hFF, 8'h0F, 8'h00};
  int         popTrace [3] = '{8, 12, 12};
  logic [7:0] negWords [3] = '{8'hFF, 8'hFE, 8'h03};

  always #5 clk = ~clk;

  stream_count_unit dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
    .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .cnt(cnt), .busy(busy), .ovf(ovf)
  );

  stream_count_unit #(.WIDTH(8), .CNT_W(8), .LEN_W(8), .SAT(1'b1)) dutSat (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
    .in_data(inData), .in_valid(inValid), .in_ready(satInReady),
    .out_data(satOutData), .out_valid(satOutValid), .out_ready(outReady),
    .cnt(satCnt), .busy(satBusy), .ovf(satOvf)
  );

  stream_count_unit #(.WIDTH(8), .CNT_W(8), .LEN_W(8), .SAT(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
    .in_data(inData), .in_valid(inValid), .in_ready(wrapInReady),
    .out_data(wrapOutData), .out_valid(wrapOutValid), .out_ready(outReady),
    .cnt(wrapCnt), .busy(wrapBusy), .ovf(wrapOvf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one edge; returns during cycle 1 (LOAD).
  task automatic applyStimulus(input logic [7:0] lenV, input logic [1:0] modeV);
    len   = lenV;
    mode  = modeV;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; mode = '0;
    inData = '0; inValid = 1'b0; outReady = 1'b0;
    tick();
    tick();
    checkOutput("rst_cnt", cnt, 32'd0);
    checkOutput("rst_out_data", outData, 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();

    // Word count, continuous input.
    outReady = 1'b1; inValid = 1'b1; inData = 8'h55;
    applyStimulus(8'd5, 2'd0);
    checkOutput("wc_busy_c1", 32'(busy), 32'd1);
    checkOutput("wc_in_ready_c1", 32'(inReady), 32'd0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      checkOutput("wc_in_ready", 32'(inReady), 32'd1);
      checkOutput("wc_out_valid_low", 32'(outValid), 32'd0);
      checkOutput("wc_cnt", cnt, 32'(c - 2));
    end
    tick();
    checkOutput("wc_out_valid_c7", 32'(outValid), 32'd1);
    checkOutput("wc_out_data", outData, 32'd5);
    checkOutput("wc_ovf", 32'(ovf), 32'd0);
    checkOutput("wc_busy_c7", 32'(busy), 32'd1);
    inValid = 1'b0;
    tick();
    checkOutput("wc_busy_c8", 32'(busy), 32'd0);
    checkOutput("wc_out_valid_c8", 32'(outValid), 32'd0);

    // Signed sum trace.
    applyStimulus(8'd4, 2'd2);
    tick();
    checkOutput("sum_cnt_clear", cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      inData = sumWords[i]; inValid = 1'b1;
      tick();
      checkOutput("sum_cnt_trace", cnt, 32'(sumTrace[i]));
    end
    inValid = 1'b0;
    checkOutput("sum_out_valid", 32'(outValid), 32'd1);
    checkOutput("sum_out_data", outData, 32'd6);
    tick();
    checkOutput("sum_idle", 32'(busy), 32'd0);

    // Popcount with gaps, started back-to-back; len/mode scrambled mid-run.
    applyStimulus(8'd3, 2'd1);
    checkOutput("pop_b2b_busy", 32'(busy), 32'd1);
    len = 8'd99; mode = 2'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      inData = popWords[i]; inValid = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("pop_cnt", cnt, 32'(popTrace[i]));
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checkOutput("pop_gap_cnt", cnt, 32'(popTrace[i]));
          checkOutput("pop_gap_remaining", 32'(dut.remaining_q), 32'(2 - i));
          checkOutput("pop_gap_in_ready", 32'(inReady), 32'd1);
        end
      end
    end
    checkOutput("pop_out_valid", 32'(outValid), 32'd1);
    checkOutput("pop_out_data", outData, 32'd12);
    tick();
    checkOutput("pop_idle", 32'(busy), 32'd0);

    // Empty run with backpressure and a stray start in WRITE.
    outReady = 1'b0;
    applyStimulus(8'd0, 2'd0);
    tick();
    checkOutput("empty_out_valid_c2", 32'(outValid), 32'd1);
    checkOutput("empty_out_data_c2", outData, 32'd0);
    checkOutput("empty_in_ready_c2", 32'(inReady), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty_out_valid_c3", 32'(outValid), 32'd1);
    checkOutput("empty_out_data_c3", outData, 32'd0);
    tick();
    checkOutput("empty_out_valid_c4", 32'(outValid), 32'd1);
    outReady = 1'b1;
    tick();
    checkOutput("empty_idle", 32'(busy), 32'd0);
    checkOutput("empty_out_valid_drop", 32'(outValid), 32'd0);
    tick();
    checkOutput("empty_start_ignored", 32'(busy), 32'd0);

    // Overflow on an 8-bit counter, both saturating and wrapping.
    applyStimulus(8'd2, 2'd2);
    tick();
    inValid = 1'b1; inData = 8'd100;
    tick();
    tick();
    inValid = 1'b0;
    checkOutput("ovf_sat_out_valid", 32'(satOutValid), 32'd1);
    checkOutput("ovf_sat_out_data", 32'(satOutData), 32'h7F);
    checkOutput("ovf_sat_flag", 32'(satOvf), 32'd1);
    checkOutput("ovf_wrap_out_data", 32'(wrapOutData), 32'hC8);
    checkOutput("ovf_wrap_flag", 32'(wrapOvf), 32'd1);
    checkOutput("ovf_wide_out_data", outData, 32'd200);
    checkOutput("ovf_wide_flag", 32'(ovf), 32'd0);
    tick();
    checkOutput("ovf_sat_hold_cnt", 32'(satCnt), 32'h7F);
    checkOutput("ovf_sat_hold_flag", 32'(satOvf), 32'd1);
    applyStimulus(8'd1, 2'd2);
    tick();
    inValid = 1'b1; inData = 8'd1;
    tick();
    inValid = 1'b0;
    checkOutput("ovf_next_out_valid", 32'(satOutValid), 32'd1);
    checkOutput("ovf_next_sat_data", 32'(satOutData), 32'd1);
    checkOutput("ovf_next_sat_flag", 32'(satOvf), 32'd0);
    checkOutput("ovf_next_wrap_data", 32'(wrapOutData), 32'd1);
    checkOutput("ovf_next_wrap_flag", 32'(wrapOvf), 32'd0);
    tick();

    // Reset mid-run (with start asserted alongside), then a fresh run.
    applyStimulus(8'd4, 2'd3);
    tick();
    inValid = 1'b1; inData = 8'hFF;
    tick();
    checkOutput("mid_cnt_1", cnt, 32'd1);
    inData = 8'h05;
    tick();
    checkOutput("mid_cnt_2", cnt, 32'd1);
    checkOutput("mid_remaining", 32'(dut.remaining_q), 32'd2);
    rst = 1'b0; start = 1'b1;
    tick();
    rst = 1'b1; start = 1'b0; inValid = 1'b0;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(inReady), 32'd0);
    checkOutput("mid_rst_cnt", cnt, 32'd0);
    checkOutput("mid_rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("mid_rst_remaining", 32'(dut.remaining_q), 32'd0);
    tick();
    checkOutput("mid_rst_beats_start", 32'(busy), 32'd0);
    applyStimulus(8'd3, 2'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      inData = negWords[i]; inValid = 1'b1;
      tick();
    end
    inValid = 1'b0;
    checkOutput("neg_out_valid", 32'(outValid), 32'd1);
    checkOutput("neg_out_data", outData, 32'd2);
    tick();
    checkOutput("neg_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
